// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// Package name: adc_sched_pkg. Imported by the interface, the averaging bank and the top.
package adc_sched_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    ACCUM  = 3'd4,
    NEXT   = 3'd5
  } state_t;

  // Running sum of SAMPLES 12-bit values never exceeds this width.
  function automatic int sum_width(input int samples);
    return ADC_W + $clog2(samples);
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// ADC-side bus of the sample scheduler.
//
// Handshake: the scheduler (master) drives adc_ch and holds it stable, then
// pulses adc_start for exactly one cycle. The converter (slave) answers with a
// one-cycle adc_done pulse; adc_data is valid only in that cycle. There is no
// back-pressure: a done pulse outside the scheduler's WAIT state is dropped.
interface adc_sample_scheduler_if #(
  parameter int CHANNELS = 4
);
  import adc_sched_pkg::*;

  logic [$clog2(CHANNELS)-1:0] adc_ch;
  logic                        adc_start;
  logic                        adc_done;
  logic [ADC_W-1:0]            adc_data;

  modport master (
    output adc_ch,
    output adc_start,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_ch,
    input  adc_start,
    output adc_done,
    output adc_data
  );

endinterface

// File: rtl/adc_sample_scheduler_avg_bank.sv
// Per-channel moving-average bank: history RAM, write pointers, running sums,
// fill counters and the power-of-two divide. One sample is absorbed per wr_en.
module adc_avg_bank
  import adc_sched_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SAMPLES  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(CHANNELS)-1:0] ch,
  input  logic [ADC_W-1:0]            sample,
  output logic [CHANNELS*ADC_W-1:0]   avg,
  output logic [CHANNELS-1:0]         valid
);

  localparam int LG = $clog2(SAMPLES);
  localparam int SW = sum_width(SAMPLES);
  localparam logic [LG:0] FULL = (LG+1)'(SAMPLES);

  logic [ADC_W-1:0] hist [CHANNELS][SAMPLES];
  logic [SW-1:0]    sum  [CHANNELS];
  logic [LG-1:0]    wp   [CHANNELS];
  logic [LG:0]      fill [CHANNELS];
  logic [SW-1:0]    new_sum;

  // Replace the oldest sample of the selected channel in the running sum.
  always_comb begin
    new_sum = sum[ch] - SW'(hist[ch][wp[ch]]) + SW'(sample);
  end

  // Window update; avg is registered straight from new_sum so it is visible
  // the cycle after wr_en, together with the updated sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]  <= '0;
        wp[c]   <= '0;
        fill[c] <= '0;
        for (int s = 0; s < SAMPLES; s++) begin
          hist[c][s] <= '0;
        end
      end
    end else if (wr_en) begin
      sum[ch]           <= new_sum;
      hist[ch][wp[ch]]  <= sample;
      // SAMPLES is a power of two, so the pointer wraps on natural overflow.
      wp[ch]            <= wp[ch] + 1'b1;
      if (fill[ch] != FULL) begin
        fill[ch] <= fill[ch] + 1'b1;
      end
      avg[ch*ADC_W +: ADC_W] <= new_sum[LG +: ADC_W];
    end
  end

  // A channel is valid once its window has been filled once.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      valid[c] = (fill[c] == FULL);
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Round-robin scheduler for one shared ADC: settle the mux, pulse start, wait
// for done (with timeout), then feed the per-channel moving-average bank.
// Optional spike rejection: define ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SAMPLES        = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
  , parameter logic [ADC_W-1:0] SPIKE_LIMIT = 12'd200
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  adc_sample_scheduler_if.master      adc,
  output logic [CHANNELS*ADC_W-1:0]   filt_data,
  output logic [CHANNELS-1:0]         filt_valid,
  output logic                        upd_strobe,
  output logic [$clog2(CHANNELS)-1:0] upd_ch,
  output logic [CHANNELS-1:0]         timeout_err,
  input  logic                        clr_err,
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
  output logic [15:0]                 reject_cnt,
`endif
  output state_t                      state_dbg
);

  localparam int CW  = $clog2(CHANNELS);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [SCW-1:0]   settle_cnt;
  logic [TCW-1:0]   tmo_cnt;
  logic [ADC_W-1:0] sample_q;
  logic [CW-1:0]    ch_q;
  logic             start_q;

  assign adc.adc_ch    = ch_q;
  assign adc.adc_start = start_q;
  assign state_dbg     = state;

`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
  logic [ADC_W-1:0] cur_avg;
  logic [ADC_W-1:0] abs_diff;
  logic             spike;
  logic [1:0]       reject_run [CHANNELS];

  // A sample is a spike only against a filled window, and only for the first
  // two in a row; the third consecutive outlier is treated as a real step.
  always_comb begin
    cur_avg  = filt_data[ch_q*ADC_W +: ADC_W];
    abs_diff = (adc.adc_data > cur_avg) ? (adc.adc_data - cur_avg) : (cur_avg - adc.adc_data);
    spike    = filt_valid[ch_q] && (abs_diff > SPIKE_LIMIT) && (reject_run[ch_q] != 2'd2);
  end
`endif

  // Sequencing FSM with registered start/update strobes and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      sample_q    <= '0;
      ch_q        <= '0;
      start_q     <= 1'b0;
      upd_strobe  <= 1'b0;
      upd_ch      <= '0;
      timeout_err <= '0;
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
      reject_cnt  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        reject_run[c] <= '0;
      end
`endif
    end else begin
      // Clear first so a timeout set later in this cycle wins.
      if (clr_err) begin
        timeout_err <= '0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
            start_q <= 1'b1;
            state   <= START;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        START: begin
          start_q <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (adc.adc_done) begin
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
            if (spike) begin
              reject_run[ch_q] <= reject_run[ch_q] + 1'b1;
              if (reject_cnt != 16'hFFFF) begin
                reject_cnt <= reject_cnt + 1'b1;
              end
              state <= NEXT;
            end else begin
              reject_run[ch_q] <= '0;
              sample_q         <= adc.adc_data;
              state            <= ACCUM;
            end
`else
            sample_q <= adc.adc_data;
            state    <= ACCUM;
`endif
          end else if (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err[ch_q] <= 1'b1;
            state             <= NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ACCUM: begin
          upd_strobe <= 1'b1;
          upd_ch     <= ch_q;
          state      <= NEXT;
        end
        NEXT: begin
          upd_strobe <= 1'b0;
          settle_cnt <= '0;
          ch_q       <= (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
          state      <= enable ? SETTLE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_avg_bank #(
    .CHANNELS (CHANNELS),
    .SAMPLES  (SAMPLES)
  ) u_avg_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (state == ACCUM),
    .ch     (ch_q),
    .sample (sample_q),
    .avg    (filt_data),
    .valid  (filt_valid)
  );

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a behavioural ADC that answers
// each start with a done pulse ADC_LAT cycles later (unless the channel is dead).
module tb_adc_sample_scheduler;
  import adc_sched_pkg::*;

  localparam int ADC_LAT = 5;
  // 16 settle + 1 start + 5 wait + 1 accum + 1 next
  localparam int CONV_PERIOD = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clr_err = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_sample_scheduler_if #(.CHANNELS(4)) adc_if ();

  logic [47:0] filt_data;
  logic [3:0]  filt_valid;
  logic        upd_strobe;
  logic [1:0]  upd_ch;
  logic [3:0]  timeout_err;
  state_t      state_dbg;
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
  logic [15:0] reject_cnt;
`endif

  adc_sample_scheduler #(
    .CHANNELS(4), .SAMPLES(8), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .adc         (adc_if.master),
    .filt_data   (filt_data),
    .filt_valid  (filt_valid),
    .upd_strobe  (upd_strobe),
    .upd_ch      (upd_ch),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
    .reject_cnt  (reject_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- ADC model and monitors ----------------
  logic [11:0] ch_val [4];
  bit          alt1 = 1'b0;
  bit          alt1_phase = 1'b0;
  int          dead_ch = -1;
  int          resp_cnt = 0;
  logic [1:0]  resp_ch = '0;

  logic [1:0]  start_ch_log[$];
  int          start_cyc_log[$];
  int          done_cyc_log[$];
  logic [1:0]  upd_ch_log[$];
  int          upd_cyc_log[$];

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    adc_if.adc_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        adc_if.adc_done = 1'b1;
        if (alt1 && resp_ch == 2'd1) begin
          adc_if.adc_data = alt1_phase ? 12'hFFF : 12'h000;
          alt1_phase = !alt1_phase;
        end else begin
          adc_if.adc_data = ch_val[resp_ch];
        end
        done_cyc_log.push_back(cyc);
      end
    end
    if (adc_if.adc_start) begin
      start_ch_log.push_back(adc_if.adc_ch);
      start_cyc_log.push_back(cyc);
      if (int'(adc_if.adc_ch) != dead_ch) begin
        resp_cnt = ADC_LAT;
        resp_ch  = adc_if.adc_ch;
      end
    end
    if (upd_strobe) begin
      upd_ch_log.push_back(upd_ch);
      upd_cyc_log.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [11:0] fd(input int c);
    return filt_data[c*12 +: 12];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    clr_err = 1'b0;
    alt1 = 1'b0;
    dead_ch = -1;
    for (int c = 0; c < 4; c++) ch_val[c] = 12'h800;
    repeat (3) step();
    rst = 1'b0;
    start_ch_log.delete();
    start_cyc_log.delete();
    done_cyc_log.delete();
    upd_ch_log.delete();
    upd_cyc_log.delete();
  endtask

  task automatic wait_upd(input int n, input int budget, input string tag);
    int k = 0;
    while (upd_ch_log.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (upd_ch_log.size() < n) begin
      failures++;
      $display("FAIL %s wait_upd: updates=%0d required=%0d", tag, upd_ch_log.size(), n);
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (start_ch_log.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (start_ch_log.size() < n) begin
      failures++;
      $display("FAIL %s wait_starts: starts=%0d required=%0d", tag, start_ch_log.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    enable = 1'b0;
    while (state_dbg != IDLE && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (state_dbg != IDLE) begin
      failures++;
      $display("FAIL wait_idle: state=%0d required=%0d", state_dbg, IDLE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    checks++; if (adc_if.adc_ch !== 2'd0) begin failures++; $display("FAIL reset_adc_ch got=%0d exp=0", adc_if.adc_ch); end
    checks++; if (adc_if.adc_start !== 1'b0) begin failures++; $display("FAIL reset_adc_start got=%b exp=0", adc_if.adc_start); end
    checks++; if (filt_data !== 48'h0) begin failures++; $display("FAIL reset_filt_data got=%h exp=0", filt_data); end
    checks++; if (filt_valid !== 4'h0) begin failures++; $display("FAIL reset_filt_valid got=%h exp=0", filt_valid); end
    checks++; if (upd_strobe !== 1'b0 || upd_ch !== 2'd0) begin failures++; $display("FAIL reset_upd got=%b/%0d exp=0/0", upd_strobe, upd_ch); end
    checks++; if (timeout_err !== 4'h0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0000", timeout_err); end
    rst = 1'b0;
    repeat (4) step();
    checks++; if (state_dbg !== IDLE || adc_if.adc_start !== 1'b0) begin failures++; $display("FAIL idle_after_reset state=%0d start=%b exp=IDLE/0", state_dbg, adc_if.adc_start); end
  endtask

  task automatic test_fill();
    logic [1:0] exp_q[$];
    do_reset();
    enable = 1'b1;
    wait_upd(4, 200, "fill4");
    // One sample of 0x800 in an 8-deep window reads as 0x800/8.
    checks++; if (filt_valid !== 4'h0) begin failures++; $display("FAIL fill4_valid got=%b exp=0000", filt_valid); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (fd(c) !== 12'h100) begin failures++; $display("FAIL fill4_data ch%0d got=%h exp=100", c, fd(c)); end
    end
    wait_upd(29, 800, "fill29");
    checks++; if (filt_valid !== 4'b0001) begin failures++; $display("FAIL fill29_valid got=%b exp=0001", filt_valid); end
    wait_upd(32, 200, "fill32");
    checks++; if (filt_valid !== 4'hF) begin failures++; $display("FAIL fill32_valid got=%b exp=1111", filt_valid); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (fd(c) !== 12'h800) begin failures++; $display("FAIL fill32_data ch%0d got=%h exp=800", c, fd(c)); end
    end
    for (int i = 0; i < 32; i++) exp_q.push_back(2'(i % 4));
    for (int i = 0; i < 32 && i < start_ch_log.size(); i++) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      checks++; if (start_ch_log[i] !== e) begin failures++; $display("FAIL order idx%0d got=%0d exp=%0d", i, start_ch_log[i], e); end
    end
    for (int i = 0; i + 1 < 32 && i + 1 < start_cyc_log.size(); i++) begin
      checks++;
      if (start_cyc_log[i+1] - start_cyc_log[i] != CONV_PERIOD) begin
        failures++;
        $display("FAIL spacing idx%0d got=%0d exp=%0d", i, start_cyc_log[i+1] - start_cyc_log[i], CONV_PERIOD);
      end
    end
    wait_idle(100);
  endtask

  task automatic test_alternate();
    do_reset();
    alt1 = 1'b1;
    alt1_phase = 1'b0;
    enable = 1'b1;
    wait_upd(8, 400, "alt8");
    // ch1 window holds {0, FFF}: 0xFFF/8 = 0x1FF; ch0 holds two 0x800 samples.
    checks++; if (fd(1) !== 12'h1FF) begin failures++; $display("FAIL alt8_ch1 got=%h exp=1ff", fd(1)); end
    checks++; if (fd(0) !== 12'h200) begin failures++; $display("FAIL alt8_ch0 got=%h exp=200", fd(0)); end
    wait_upd(32, 800, "alt32");
    // Four 0 and four 0xFFF: 4*4095/8 = 2047.
    checks++; if (fd(1) !== 12'h7FF) begin failures++; $display("FAIL alt32_ch1 got=%h exp=7ff", fd(1)); end
    checks++; if (filt_valid !== 4'hF) begin failures++; $display("FAIL alt32_valid got=%b exp=1111", filt_valid); end
    for (int i = 0; i < upd_cyc_log.size() && i < done_cyc_log.size(); i++) begin
      checks++;
      if (upd_cyc_log[i] - done_cyc_log[i] != 2) begin
        failures++;
        $display("FAIL latency idx%0d got=%0d exp=2", i, upd_cyc_log[i] - done_cyc_log[i]);
      end
    end
    wait_idle(100);
    alt1 = 1'b0;
  endtask

  task automatic test_timeout();
    int s;
    int k;
    int n2;
    int ns;
    do_reset();
    dead_ch = 2;
    enable = 1'b1;
    wait_starts(3, 200, "tmo_start2");
    s = start_cyc_log[2];
    k = 0;
    while (timeout_err === 4'h0 && k < 1200) begin step(); k++; end
    // WAIT lasts TIMEOUT_CYCLES cycles; the flag is visible the cycle after.
    checks++; if (cyc - s != 1025) begin failures++; $display("FAIL tmo_delay got=%0d exp=1025", cyc - s); end
    checks++; if (timeout_err !== 4'b0100) begin failures++; $display("FAIL tmo_flag got=%b exp=0100", timeout_err); end
    ns = start_ch_log.size();
    wait_starts(ns + 1, 100, "tmo_next");
    if (start_ch_log.size() > ns) begin
      checks++; if (start_ch_log[ns] !== 2'd3) begin failures++; $display("FAIL tmo_next_ch got=%0d exp=3", start_ch_log[ns]); end
    end
    n2 = 0;
    foreach (upd_ch_log[i]) if (upd_ch_log[i] == 2'd2) n2++;
    checks++; if (n2 != 0) begin failures++; $display("FAIL tmo_no_upd ch2 updates=%0d exp=0", n2); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (timeout_err !== 4'h0) begin failures++; $display("FAIL clr_err got=%b exp=0000", timeout_err); end
    k = 0;
    while (timeout_err === 4'h0 && k < 1500) begin step(); k++; end
    checks++; if (timeout_err !== 4'b0100) begin failures++; $display("FAIL tmo_reset got=%b exp=0100", timeout_err); end
    wait_idle(1200);
    dead_ch = -1;
  endtask

  task automatic test_enable_drop();
    int ns;
    do_reset();
    enable = 1'b1;
    wait_starts(2, 200, "en_start1");
    step();
    enable = 1'b0;
    wait_upd(2, 50, "en_upd1");
    if (upd_ch_log.size() >= 2) begin
      checks++; if (upd_ch_log[1] !== 2'd1) begin failures++; $display("FAIL en_upd_ch got=%0d exp=1", upd_ch_log[1]); end
    end
    repeat (3) step();
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL en_idle got=%0d exp=%0d", state_dbg, IDLE); end
    checks++; if (adc_if.adc_start !== 1'b0) begin failures++; $display("FAIL en_start got=%b exp=0", adc_if.adc_start); end
    checks++; if (adc_if.adc_ch !== 2'd2) begin failures++; $display("FAIL en_ch got=%0d exp=2", adc_if.adc_ch); end
    ns = start_ch_log.size();
    repeat (60) step();
    checks++; if (start_ch_log.size() != ns) begin failures++; $display("FAIL en_quiet starts=%0d exp=%0d", start_ch_log.size(), ns); end
    enable = 1'b1;
    wait_starts(ns + 1, 100, "en_resume");
    if (start_ch_log.size() > ns) begin
      checks++; if (start_ch_log[ns] !== 2'd2) begin failures++; $display("FAIL en_resume_ch got=%0d exp=2", start_ch_log[ns]); end
    end
    wait_upd(3, 100, "en_upd2");
    checks++; if (fd(0) !== 12'h100 || fd(1) !== 12'h100 || fd(2) !== 12'h100 || fd(3) !== 12'h000) begin
      failures++;
      $display("FAIL en_history got=%h exp=000100100100", filt_data);
    end
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_val[0] = 12'hFFF;
    enable = 1'b1;
    wait_starts(1, 100, "rm_start");
    repeat (2) step();
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    checks++; if (upd_ch_log.size() != 0) begin failures++; $display("FAIL rm_no_upd updates=%0d exp=0", upd_ch_log.size()); end
    checks++; if (filt_data !== 48'h0 || filt_valid !== 4'h0) begin failures++; $display("FAIL rm_filt got=%h/%b exp=0/0", filt_data, filt_valid); end
    checks++; if (state_dbg !== IDLE || adc_if.adc_ch !== 2'd0) begin failures++; $display("FAIL rm_state got=%0d/%0d exp=IDLE/0", state_dbg, adc_if.adc_ch); end
    checks++; if (upd_strobe !== 1'b0 || upd_ch !== 2'd0 || timeout_err !== 4'h0) begin
      failures++;
      $display("FAIL rm_outputs got=%b/%0d/%b exp=0/0/0000", upd_strobe, upd_ch, timeout_err);
    end
  endtask

`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
  task automatic test_spike();
    int k;
    int nu;
    bit seen;
    do_reset();
    enable = 1'b1;
    wait_upd(32, 1000, "sp_fill");
    ch_val[0] = 12'hC00;
    k = 0;
    while (reject_cnt == 16'd0 && k < 200) begin step(); k++; end
    checks++; if (reject_cnt !== 16'd1) begin failures++; $display("FAIL sp_cnt1 got=%0d exp=1", reject_cnt); end
    checks++; if (fd(0) !== 12'h800) begin failures++; $display("FAIL sp_hold got=%h exp=800", fd(0)); end
    nu = upd_ch_log.size();
    seen = 1'b0;
    k = 0;
    while (!seen && k < 300) begin
      step();
      k++;
      for (int i = nu; i < upd_ch_log.size(); i++) if (upd_ch_log[i] == 2'd0) seen = 1'b1;
    end
    // Third outlier accepted: (7*0x800 + 0xC00)/8 = 0x880.
    checks++; if (fd(0) !== 12'h880) begin failures++; $display("FAIL sp_accept got=%h exp=880", fd(0)); end
    checks++; if (reject_cnt !== 16'd2) begin failures++; $display("FAIL sp_cnt2 got=%0d exp=2", reject_cnt); end
    wait_idle(100);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int c = 0; c < 4; c++) ch_val[c] = 12'h800;
    test_reset();
    test_fill();
    test_alternate();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
`ifdef ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN
    test_spike();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Sequences one shared 12-bit ADC across CHANNELS thermistor/sense inputs in round-robin order: mux settle, start conversion, wait for done.
- Keeps a per-channel moving average over SAMPLES conversions and publishes it with per-channel valid flags and timeout flags.
- Sits between the ADC interface and the temperature-control loops; it replaces free-running per-channel filtering.

Parameters:
- CHANNELS, 4, number of sequenced inputs (2..8).
- SAMPLES, 8, averaging window per channel; must be a power of two (2..64).
- SETTLE_CYCLES, 16, clk cycles between channel select change and conversion start (>=1).
- TIMEOUT_CYCLES, 1024, maximum clk cycles spent waiting for adc_done.
- SPIKE_LIMIT, 12'd200, rejection threshold; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run sequencing.
- adc_ch  out  $clog2(CHANNELS)  analog mux select.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  conversion complete; one-cycle pulse.
- adc_data  in  12  conversion result; valid while adc_done=1.
- filt_data  out  CHANNELS*12  averaged value per channel; channel k occupies [12k+11:12k].
- filt_valid  out  CHANNELS  channel window filled.
- upd_strobe  out  1  one-cycle pulse when a channel's filt_data updates.
- upd_ch  out  $clog2(CHANNELS)  channel updated by upd_strobe.
- timeout_err  out  CHANNELS  sticky conversion-timeout flags.
- clr_err  in  1  clears all timeout_err bits.

Behaviour:
- Reset:
  - state=IDLE, adc_ch=0, adc_start=0.
  - filt_data=0, filt_valid=0, upd_strobe=0, upd_ch=0, timeout_err=0.
  - All history, sums and fill counters are 0.
  - Reset mid-conversion aborts immediately; a later adc_done is ignored.
- IDLE: leave for SETTLE when enable=1; adc_ch holds its current value.
- SETTLE: count SETTLE_CYCLES with adc_ch stable, then go to START.
- START:
  - adc_start=1 for exactly one cycle; go to WAIT.
  - Arm the timeout counter to 0.
- WAIT:
  - On adc_done=1, latch adc_data and go to ACCUM.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: set timeout_err[adc_ch], discard the sample, go to NEXT.
  - adc_done is ignored in every state other than WAIT.
- ACCUM (1 cycle) for channel c:
  - sum[c] = sum[c] - hist[c][wp[c]] + sample; hist[c][wp[c]] = sample.
  - wp[c] wraps from SAMPLES-1 to 0.
  - sum width = 12 + log2(SAMPLES); no overflow possible.
  - filt_data[c] = sum[c] >> log2(SAMPLES), registered.
  - Fill count saturates at SAMPLES; filt_valid[c]=1 once it reaches SAMPLES.
- NEXT (1 cycle):
  - upd_strobe=1 and upd_ch=c only if ACCUM ran (not after a timeout).
  - adc_ch increments, wrapping from CHANNELS-1 to 0.
  - If enable=1 go to SETTLE, else go to IDLE.
- Latency: adc_done seen in WAIT at cycle T -> filt_data and upd_strobe visible at T+2.
- Enable deassert mid-sequence:
  - The current conversion (or its timeout) completes and NEXT runs, then IDLE.
  - History and the channel pointer are retained; resuming starts at the next channel.
- clr_err:
  - Clears all timeout_err bits.
  - If clr_err coincides with a new timeout on the same channel, the set wins.
- Before filt_valid, filt_data is still the partial sum >> log2(SAMPLES) (under-reads by design).

Optional Feature:
- Macro: ADC_SAMPLE_SCHEDULER_SPIKE_REJECT_EN.
- Enabled:
  - When filt_valid[c]=1 and |sample - filt_data[c]| > SPIKE_LIMIT, the sample is dropped.
  - On a drop: no ACCUM, no upd_strobe, and per-channel reject_run increments.
  - The 3rd consecutive out-of-limit sample is accepted and resets reject_run. This lets genuine steps through.
  - Adds output reject_cnt (16 bits, saturating, total drops; reset to 0).
- Disabled: every completed sample is accumulated; reject_cnt is absent.

Decomposition:
- Package adc_sched_pkg:
  - ADC_W=12.
  - State enum {IDLE, SETTLE, START, WAIT, ACCUM, NEXT}.
  - Sum-width function of SAMPLES.
- Sub-module adc_avg_bank:
  - Holds per-channel history RAM, write pointers, sums, fill counters and the shift divide.
  - Interface: wr_en/ch/sample in; avg/valid vectors out.
- The scheduler FSM, timers and error flags stay in the top module.

Test Plan:
- CHANNELS=4, SAMPLES=8, ADC model returns 12'h800 on every channel 5 cycles after start:
  - After 32 conversions, filt_valid=4'hF and all filt_data=12'h800.
  - adc_ch order is 0,1,2,3,0…
  - Start-to-start spacing is constant.
- Channel 1 fed 0 then 12'hFFF repeatedly:
  - After its 8th sample, filt_data[1]=12'h7FF.
  - upd_strobe appears 2 cycles after each done.
- ADC never asserts done on channel 2:
  - timeout_err=4'b0100 after TIMEOUT_CYCLES.
  - Sequencing continues with channel 3.
  - clr_err clears the flag; it re-sets on the next pass.
- enable dropped during WAIT:
  - Done is still accepted and NEXT runs, then IDLE with adc_start=0.
  - Re-enable resumes at the next channel with history intact.
- rst asserted in WAIT, then a late adc_done:
  - All outputs return to 0.
  - No update occurs from the stale done.
- Spike test (macro on, limit 200, average 12'h800):
  - One 12'hC00 sample is dropped and reject_cnt=1.
  - Three consecutive 12'hC00 samples: the third is accepted.
